operand_skid_buffer: RTL and testbench

- 16-bit, 2-entry elastic pipeline register that captures the output of the 16-bit 2:1 operand/PC-source mux and presents it to the next stage (ALU operand latch / PC load).
- Valid/ready handshake on both sides, with a skid entry so upstream sees a registered-only ready and downstream stalls never lose a word.
- Synchronous flush discards buffered words on branch/jump redirect.

---
 rtl/operand_skid_buffer_pkg.sv | 11 +
 rtl/operand_skid_buffer.sv | 90 +++++++++
 tb/tb_operand_skid_buffer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/operand_skid_buffer_pkg.sv
// Shared constants for the operand skid buffer: state encoding and datapath width.
// The state codes equal the buffered word count, so occupancy is the state itself.
package operand_skid_buffer_pkg;

    localparam int DATA_WIDTH = 16;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

endpackage

// File: rtl/operand_skid_buffer.sv
// Two-entry elastic register between the operand/PC-source mux and the next stage.
// in_ready comes from registered state only, so upstream never sees a path from out_ready.
module operand_skid_buffer
    import operand_skid_buffer_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign out_data  = main_q;

    // Flush wins over every transition and suppresses all data loads.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        load_main_in = 1'b1;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (out_ready && in_valid) begin
                        load_main_in = 1'b1;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end else if (in_valid) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        load_main_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_operand_skid_buffer.sv
// Directed, table-driven bench for operand_skid_buffer with hand-written reset,
// flush and asynchronous-reset sequences.
module tb_operand_skid_buffer;

    logic        clock;
    logic        reset;
    logic [15:0] inData;
    logic        inValid;
    logic        inReady;
    logic        flush;
    logic [15:0] outData;
    logic        outValid;
    logic        outReady;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        fl;
        logic        eov;
        logic [15:0] edata;
        logic        chkd;
        logic        eir;
        logic [1:0]  eocc;
        string       name;
    } vec_t;

    vec_t vecs[$];

    operand_skid_buffer dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (inData),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .flush     (flush),
        .out_data  (outData),
        .out_valid (outValid),
        .out_ready (outReady),
        .occupancy (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic iv, input logic [15:0] id,
                                 input logic ordy, input logic fl);
        inValid  = iv;
        inData   = id;
        outReady = ordy;
        flush    = fl;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic eov, input logic [15:0] edata,
                               input logic chkd, input logic eir, input logic [1:0] eocc);
        checks++;
        if (outValid !== eov) begin
            failures++;
            $display("[TB] FAIL %s out_valid got %b want %b", name, outValid, eov);
        end
        checks++;
        if (inReady !== eir) begin
            failures++;
            $display("[TB] FAIL %s in_ready got %b want %b", name, inReady, eir);
        end
        checks++;
        if (occupancy !== eocc) begin
            failures++;
            $display("[TB] FAIL %s occupancy got %0d want %0d", name, occupancy, eocc);
        end
        if (chkd) begin
            checks++;
            if (outData !== edata) begin
                failures++;
                $display("[TB] FAIL %s out_data got %h want %h", name, outData, edata);
            end
        end
    endtask

    function automatic vec_t mk(input string name, input logic iv, input logic [15:0] id,
                                input logic ordy, input logic fl, input logic eov,
                                input logic [15:0] edata, input logic chkd,
                                input logic eir, input logic [1:0] eocc);
        vec_t v;
        v.name = name; v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.eov = eov; v.edata = edata; v.chkd = chkd; v.eir = eir; v.eocc = eocc;
        return v;
    endfunction

    initial begin
        // Expected state after each edge; the table starts in ONE holding ABCD.
        vecs.push_back(mk("drain_abcd", 0, 16'h0000, 1, 0, 0, 16'hABCD, 1, 1, 2'd0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk("stream", 1, 16'(k), 1, 0, 1, 16'(k), 1, 1, 2'd1));
        vecs.push_back(mk("stream_drain", 0, 16'h0000, 1, 0, 0, 16'h0008, 1, 1, 2'd0));
        vecs.push_back(mk("bp_push1", 1, 16'h1111, 0, 0, 1, 16'h1111, 1, 1, 2'd1));
        vecs.push_back(mk("bp_push2", 1, 16'h2222, 0, 0, 1, 16'h1111, 1, 0, 2'd2));
        vecs.push_back(mk("bp_push3_refused", 1, 16'h3333, 0, 0, 1, 16'h1111, 1, 0, 2'd2));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk("stable", 1, (k % 2) ? 16'hCCCC : 16'h3333, 0, 0,
                              1, 16'h1111, 1, 0, 2'd2));
        vecs.push_back(mk("bp_pop1", 1, 16'h3333, 1, 0, 1, 16'h2222, 1, 1, 2'd1));
        vecs.push_back(mk("bp_pop2_push3", 1, 16'h3333, 1, 0, 1, 16'h3333, 1, 1, 2'd1));
        vecs.push_back(mk("bp_drain", 0, 16'h0000, 1, 0, 0, 16'h3333, 1, 1, 2'd0));
        vecs.push_back(mk("fl_push1", 1, 16'h4444, 0, 0, 1, 16'h4444, 1, 1, 2'd1));
        vecs.push_back(mk("fl_push2", 1, 16'h6666, 0, 0, 1, 16'h4444, 1, 0, 2'd2));
        vecs.push_back(mk("flush_full", 1, 16'h5555, 0, 1, 0, 16'h4444, 1, 1, 2'd0));
        vecs.push_back(mk("after_flush", 0, 16'h5555, 0, 0, 0, 16'h4444, 1, 1, 2'd0));
        vecs.push_back(mk("refill", 1, 16'h9999, 0, 0, 1, 16'h9999, 1, 1, 2'd1));
        vecs.push_back(mk("flush_one", 1, 16'h5555, 1, 1, 0, 16'h9999, 1, 1, 2'd0));
        vecs.push_back(mk("ones", 1, 16'hFFFF, 1, 0, 1, 16'hFFFF, 1, 1, 2'd1));
        vecs.push_back(mk("zeros", 1, 16'h0000, 1, 0, 1, 16'h0000, 1, 1, 2'd1));
        vecs.push_back(mk("final_drain", 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 2'd0));

        // Reset held low for three edges while upstream offers a word.
        reset    = 1'b0;
        inValid  = 1'b1;
        inData   = 16'hABCD;
        outReady = 1'b0;
        flush    = 1'b0;
        #1;
        checkOutput("reset_async", 0, 16'h0000, 1, 1, 2'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            checkOutput("reset_hold", 0, 16'h0000, 1, 1, 2'd0);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("first_accept", 1, 16'hABCD, 1, 1, 2'd1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl);
            checkOutput(vecs[i].name, vecs[i].eov, vecs[i].edata, vecs[i].chkd,
                        vecs[i].eir, vecs[i].eocc);
        end

        // Asynchronous reset between edges while holding one word.
        applyStimulus(1, 16'h7777, 0, 0);
        checkOutput("pre_async", 1, 16'h7777, 1, 1, 2'd1);
        inValid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 0, 16'h0000, 1, 1, 2'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        applyStimulus(1, 16'h8888, 1, 0);
        checkOutput("post_reset_push", 1, 16'h8888, 1, 1, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
